// File: rtl/reg_file_io.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_io
// Purpose  : CPU register file with NREGS-1 general-purpose registers and a
//            memory-mapped I/O slot at address NREGS-1. It has two
//            combinational read ports and one synchronous write port. The I/O
//            slot is buffered in each direction by a one-entry register with
//            a valid/ready handshake.
// Revision : 1.0  initial release
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   ra_a/ra_d/ra_take     read port A; ra_take consumes the I/O input word
//   rb_a/rb_d             read port B; never consumes
//   we/wa/wd              synchronous write port
//   io_stall              write to I/O refused this cycle (retry required)
//   io_in_avail           input holding register full
//   user_in/user_valid/user_ready           external input handshake
//   user_out/user_out_valid/user_out_ready  external output handshake
//
// Build option
//   REG_FILE_BYPASS_EN    when defined, GP writes are forwarded combinationally
//                         to a read port that addresses the same register
//                         in the same cycle. I/O reads are never forwarded.
// ============================================================================
module reg_file_io #(
  parameter  int WIDTH = 8,
  parameter  int NREGS = 4,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    ra_a,
  output logic [WIDTH-1:0] ra_d,
  input  logic             ra_take,
  input  logic [AW-1:0]    rb_a,
  output logic [WIDTH-1:0] rb_d,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  output logic             io_stall,
  output logic             io_in_avail,
  input  logic [WIDTH-1:0] user_in,
  input  logic             user_valid,
  output logic             user_ready,
  output logic [WIDTH-1:0] user_out,
  output logic             user_out_valid,
  input  logic             user_out_ready
);

  localparam logic [AW-1:0] IO_ADDR = AW'(NREGS - 1);

  logic [WIDTH-1:0] gp_q [NREGS-1];
  logic [WIDTH-1:0] in_buf_q,  in_buf_d;
  logic             in_full_q, in_full_d;
  logic [WIDTH-1:0] out_buf_q, out_buf_d;
  logic             out_full_q, out_full_d;

  logic wr_io;
  logic wr_gp;
  logic io_accept;

  assign wr_io     = we && (wa == IO_ADDR);
  assign wr_gp     = we && (wa != IO_ADDR);
  // A full output register can still take a word in the cycle it drains.
  assign io_accept = wr_io && (!out_full_q || user_out_ready);

  // Next-state logic for both I/O buffers
  always_comb begin
    in_buf_d   = in_buf_q;
    in_full_d  = in_full_q;
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;

    // Capture only when empty, so capture and take never coincide.
    if (user_valid && !in_full_q) begin
      in_buf_d  = user_in;
      in_full_d = 1'b1;
    end else if (ra_take && (ra_a == IO_ADDR) && in_full_q) begin
      in_full_d = 1'b0;
    end

    if (io_accept) begin
      out_buf_d  = wd;
      out_full_d = 1'b1;
    end else if (out_full_q && user_out_ready) begin
      out_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS - 1; i++) begin
        gp_q[i] <= '0;
      end
      in_buf_q   <= '0;
      in_full_q  <= 1'b0;
      out_buf_q  <= '0;
      out_full_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS - 1; i++) begin
        if (wr_gp && (wa == AW'(i))) begin
          gp_q[i] <= wd;
        end
      end
      in_buf_q   <= in_buf_d;
      in_full_q  <= in_full_d;
      out_buf_q  <= out_buf_d;
      out_full_q <= out_full_d;
    end
  end

  // Combinational read ports
  always_comb begin
    ra_d = '0;
    rb_d = '0;
    if (ra_a == IO_ADDR) ra_d = in_buf_q;
    if (rb_a == IO_ADDR) rb_d = in_buf_q;
    for (int i = 0; i < NREGS - 1; i++) begin
      if (ra_a == AW'(i)) ra_d = gp_q[i];
      if (rb_a == AW'(i)) rb_d = gp_q[i];
    end
`ifdef REG_FILE_BYPASS_EN
    // wr_gp already excludes the I/O address, so I/O is never forwarded.
    if (wr_gp && (wa == ra_a)) ra_d = wd;
    if (wr_gp && (wa == rb_a)) rb_d = wd;
`else
`endif
  end

  assign io_stall       = wr_io && out_full_q && !user_out_ready;
  assign io_in_avail    = in_full_q;
  assign user_ready     = !in_full_q;
  assign user_out       = out_buf_q;
  assign user_out_valid = out_full_q;

endmodule
`default_nettype wire
